// File: rtl/echo_delay_ctrl_if.sv
// ---------------------------------------------------------------------------
// echo_delay_ctrl_if
// Command/status bundle between the echo delay controller and the delay FIFO.
//   fifo_wr    : controller -> FIFO, one-cycle write enable
//   fifo_rd    : controller -> FIFO, one-cycle read enable
//   fifo_sclr  : controller -> FIFO, synchronous clear
//   fifo_full  : FIFO -> controller, full flag
//   fifo_empty : FIFO -> controller, empty flag
// master = controller side, slave = FIFO side.
// ---------------------------------------------------------------------------
interface echo_delay_ctrl_if;
  logic fifo_wr;
  logic fifo_rd;
  logic fifo_sclr;
  logic fifo_full;
  logic fifo_empty;

  modport master (
    output fifo_wr,
    output fifo_rd,
    output fifo_sclr,
    input  fifo_full,
    input  fifo_empty
  );

  modport slave (
    input  fifo_wr,
    input  fifo_rd,
    input  fifo_sclr,
    output fifo_full,
    output fifo_empty
  );
endinterface

// File: rtl/echo_delay_ctrl.sv
// ---------------------------------------------------------------------------
// echo_delay_ctrl
// Sequencing controller for the echo delay-line FIFO. Converts the ADC
// sample-valid level into FIFO write/read/clear commands so that the FIFO
// holds exactly D = (delay_sel+1) << STEP_LOG2 samples, and gates the echo
// feedback term until the delay line is primed.
// Ports:
//   sysclk     : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   data_valid : ADC sample-valid level, asynchronous to sysclk
//   enable     : echo on/off request
//   delay_sel  : delay select (3 bits)
//   fifo       : FIFO command/status bundle (master side)
//   echo_gate  : 1 = datapath applies the delayed sample
//   fill_level : words written and not yet read (DEPTH_LOG2+1 bits)
//   err        : sticky overflow/underflow protocol error
// ---------------------------------------------------------------------------
module echo_delay_ctrl #(
  parameter int DEPTH_LOG2 = 13,
  parameter int STEP_LOG2  = 10
) (
  input  logic                  sysclk,
  input  logic                  rst_n,
  input  logic                  data_valid,
  input  logic                  enable,
  input  logic [2:0]            delay_sel,
  echo_delay_ctrl_if.master     fifo,
  output logic                  echo_gate,
  output logic [DEPTH_LOG2:0]   fill_level,
  output logic                  err
);

  localparam int LW = DEPTH_LOG2 + 1;

  typedef enum logic [2:0] {
    ST_CLEAR = 3'd0,
    ST_IDLE  = 3'd1,
    ST_FILL  = 3'd2,
    ST_RUN   = 3'd3,
    ST_FLUSH = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [2:0]      sel_q, sel_d;
  logic            sync1_q, sync2_q, sync3_q;
  logic [LW-1:0]   fill_q, fill_d;
  logic            wr_q, wr_d;
  logic            rd_q, rd_d;
  logic            sclr_q, sclr_d;
  logic            gate_q, gate_d;
  logic            err_q, err_d;

  logic            strb_s;
  logic            flush_s;
  logic [LW-1:0]   sel_ext_s;
  logic [LW-1:0]   target_s;
  logic [LW-1:0]   fill_inc_s;

  // Two-flop synchronizer for data_valid plus one history flop for edge detect
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= data_valid;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign strb_s     = sync2_q & ~sync3_q;
  // Mode change: echo switched off or a different delay requested
  assign flush_s    = ~enable | (delay_sel != sel_q);
  assign sel_ext_s  = LW'({1'b0, sel_q}) + LW'(4'd1);
  assign target_s   = sel_ext_s << STEP_LOG2;
  assign fill_inc_s = fill_q + LW'(1'b1);

  // State and registered-output flops
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_CLEAR;
      sel_q   <= 3'd0;
      fill_q  <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      sclr_q  <= 1'b1;
      gate_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      fill_q  <= fill_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      sclr_q  <= sclr_d;
      gate_q  <= gate_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic; the mode-change condition outranks a sample strobe
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    case (state_q)
      ST_CLEAR: state_d = ST_IDLE;
      ST_IDLE: begin
        if (enable) begin
          sel_d   = delay_sel;
          state_d = ST_FILL;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FILL: begin
        if (flush_s) begin
          state_d = ST_FLUSH;
        end else if (strb_s && (fill_inc_s == target_s)) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_FILL;
        end
      end
      ST_RUN: begin
        if (flush_s) begin
          state_d = ST_FLUSH;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FLUSH: state_d = ST_IDLE;
      default:  state_d = ST_CLEAR;
    endcase
  end

  // Output next-values; each output registers one cycle after its cause
  always_comb begin
    wr_d   = 1'b0;
    rd_d   = 1'b0;
    sclr_d = 1'b0;
    gate_d = 1'b0;
    fill_d = fill_q;
    case (state_q)
      ST_CLEAR: begin
        // keeps sclr high for one cycle after reset release
        sclr_d = 1'b1;
        fill_d = '0;
      end
      ST_IDLE: fill_d = '0;
      ST_FILL: begin
        if (flush_s) begin
          sclr_d = 1'b1;
          fill_d = '0;
        end else if (strb_s) begin
          wr_d   = 1'b1;
          fill_d = fill_inc_s;
        end else begin
          fill_d = fill_q;
        end
      end
      ST_RUN: begin
        if (flush_s) begin
          sclr_d = 1'b1;
          fill_d = '0;
        end else begin
          // gate rises one cycle after the final fill write
          gate_d = 1'b1;
          if (strb_s) begin
            wr_d = 1'b1;
            rd_d = 1'b1;
          end else begin
            wr_d = 1'b0;
            rd_d = 1'b0;
          end
        end
      end
      ST_FLUSH: fill_d = '0;
      default: begin
        sclr_d = 1'b1;
        fill_d = '0;
      end
    endcase
  end

  // Sticky protocol error, judged on the command the FIFO is currently seeing
  always_comb begin
    if ((state_q != ST_IDLE) && (state_d == ST_IDLE)) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q
            | (wr_q & fifo.fifo_full & ~rd_q)
            | (rd_q & fifo.fifo_empty);
    end
  end

  assign fifo.fifo_wr   = wr_q;
  assign fifo.fifo_rd   = rd_q;
  assign fifo.fifo_sclr = sclr_q;
  assign echo_gate      = gate_q;
  assign fill_level     = fill_q;
  assign err            = err_q;

endmodule

// File: tb/tb_echo_delay_ctrl.sv
// ---------------------------------------------------------------------------
// tb_echo_delay_ctrl
// Scoreboard bench for echo_delay_ctrl: each data_valid pulse pushes the
// expected {fifo_wr, fifo_rd, fill_level} command; a monitor pops and
// compares whenever the DUT issues a FIFO command.
// ---------------------------------------------------------------------------
module tb_echo_delay_ctrl;

  logic        sysclk = 1'b0;
  logic        rst_n;
  logic        data_valid;
  logic        enable;
  logic [2:0]  delay_sel;
  logic        echo_gate;
  logic [13:0] fill_level;
  logic        err;

  echo_delay_ctrl_if fifo_if ();

  echo_delay_ctrl #(.DEPTH_LOG2(13), .STEP_LOG2(10)) dut (
    .sysclk     (sysclk),
    .rst_n      (rst_n),
    .data_valid (data_valid),
    .enable     (enable),
    .delay_sel  (delay_sel),
    .fifo       (fifo_if),
    .echo_gate  (echo_gate),
    .fill_level (fill_level),
    .err        (err)
  );

  always #5 sysclk = ~sysclk;

  int          checks   = 0;
  int          failures = 0;
  logic [15:0] sb_q[$];
  logic [15:0] mon_obs;
  logic [15:0] mon_exp;

  // model of the delay line
  int m_d;
  int m_fill;
  bit m_run;

  // Monitor: every FIFO command issued must match the next scoreboard entry
  always @(negedge sysclk) begin
    if (rst_n === 1'b1 && (fifo_if.fifo_wr === 1'b1 || fifo_if.fifo_rd === 1'b1)) begin
      mon_obs = {fifo_if.fifo_wr, fifo_if.fifo_rd, fill_level};
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_cmd got wr/rd/fill=%h expected no command", mon_obs);
      end else begin
        mon_exp = sb_q.pop_front();
        if (mon_obs !== mon_exp) begin
          failures++;
          $display("FAIL fifo_cmd got wr/rd/fill=%h expected=%h", mon_obs, mon_exp);
        end
      end
    end
  end

  task automatic model_start(input int d);
    m_d    = d;
    m_fill = 0;
    m_run  = 1'b0;
  endtask

  // One ADC sample: push expectation, then a 4-cycle data_valid pulse
  task automatic send_sample();
    if (!m_run) begin
      m_fill++;
      sb_q.push_back({1'b1, 1'b0, 14'(m_fill)});
      if (m_fill == m_d) m_run = 1'b1;
    end else begin
      sb_q.push_back({1'b1, 1'b1, 14'(m_d)});
    end
    data_valid = 1'b1;
    repeat (2) @(negedge sysclk);
    data_valid = 1'b0;
    repeat (2) @(negedge sysclk);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 20; i++) begin
      if (sb_q.size() == 0) break;
      @(negedge sysclk);
    end
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain pending=%0d required=0", name, sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    data_valid = 1'b0;
    enable     = 1'b0;
    delay_sel  = 3'd0;
    fifo_if.fifo_full  = 1'b0;
    fifo_if.fifo_empty = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge sysclk);
      checks++;
      if ({fifo_if.fifo_sclr, fifo_if.fifo_wr, fifo_if.fifo_rd, echo_gate, err, fill_level}
          !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 14'd0}) begin
        failures++;
        $display("FAIL reset_hold sclr=%b wr=%b rd=%b gate=%b err=%b fill=%0d required sclr=1 others 0",
                 fifo_if.fifo_sclr, fifo_if.fifo_wr, fifo_if.fifo_rd, echo_gate, err, fill_level);
      end
    end
    rst_n = 1'b1;
    @(negedge sysclk);
    checks++;
    if (fifo_if.fifo_sclr !== 1'b1) begin
      failures++;
      $display("FAIL reset_sclr_tail sclr=%b required=1", fifo_if.fifo_sclr);
    end
    @(negedge sysclk);
    checks++;
    if ({fifo_if.fifo_sclr, fifo_if.fifo_wr, fifo_if.fifo_rd, echo_gate, err, fill_level}
        !== {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 14'd0}) begin
      failures++;
      $display("FAIL reset_idle sclr=%b wr=%b rd=%b gate=%b err=%b fill=%0d required all 0",
               fifo_if.fifo_sclr, fifo_if.fifo_wr, fifo_if.fifo_rd, echo_gate, err, fill_level);
    end
  endtask

  task automatic test_fill_to_run();
    enable    = 1'b1;
    delay_sel = 3'd0;
    repeat (2) @(negedge sysclk);
    model_start(1024);
    for (int i = 0; i < 1024; i++) begin
      send_sample();
      if (i == 511) begin
        checks++;
        if (echo_gate !== 1'b0) begin
          failures++;
          $display("FAIL fill_gate_low gate=%b required=0", echo_gate);
        end
      end
    end
    checks++;
    if ({echo_gate, fill_level} !== {1'b1, 14'd1024}) begin
      failures++;
      $display("FAIL fill_done gate=%b fill=%0d required gate=1 fill=1024", echo_gate, fill_level);
    end
    send_sample();
    checks++;
    if (fill_level !== 14'd1024) begin
      failures++;
      $display("FAIL run_fill_hold fill=%0d required=1024", fill_level);
    end
    wait_drain("fill_to_run");
  endtask

  task automatic test_delay_change();
    delay_sel = 3'd2;
    @(negedge sysclk);
    checks++;
    if ({fifo_if.fifo_sclr, echo_gate, fill_level} !== {1'b1, 1'b0, 14'd0}) begin
      failures++;
      $display("FAIL change_flush sclr=%b gate=%b fill=%0d required sclr=1 gate=0 fill=0",
               fifo_if.fifo_sclr, echo_gate, fill_level);
    end
    @(negedge sysclk);
    checks++;
    if (fifo_if.fifo_sclr !== 1'b0) begin
      failures++;
      $display("FAIL change_sclr_single sclr=%b required=0", fifo_if.fifo_sclr);
    end
    @(negedge sysclk);
    model_start(3072);
    for (int i = 0; i < 3072; i++) send_sample();
    checks++;
    if ({echo_gate, fill_level} !== {1'b1, 14'd3072}) begin
      failures++;
      $display("FAIL refill_done gate=%b fill=%0d required gate=1 fill=3072", echo_gate, fill_level);
    end
    wait_drain("delay_change");
  endtask

  task automatic test_collision();
    // strb lands in the same cycle that enable is seen low
    data_valid = 1'b1;
    repeat (2) @(negedge sysclk);
    data_valid = 1'b0;
    enable     = 1'b0;
    @(negedge sysclk);
    checks++;
    if ({fifo_if.fifo_wr, fifo_if.fifo_rd, fifo_if.fifo_sclr, fill_level}
        !== {1'b0, 1'b0, 1'b1, 14'd0}) begin
      failures++;
      $display("FAIL collision_flush wr=%b rd=%b sclr=%b fill=%0d required wr=0 rd=0 sclr=1 fill=0",
               fifo_if.fifo_wr, fifo_if.fifo_rd, fifo_if.fifo_sclr, fill_level);
    end
    @(negedge sysclk);
    checks++;
    if ({fifo_if.fifo_wr, fifo_if.fifo_rd, fifo_if.fifo_sclr, echo_gate, fill_level}
        !== {1'b0, 1'b0, 1'b0, 1'b0, 14'd0}) begin
      failures++;
      $display("FAIL collision_idle wr=%b rd=%b sclr=%b gate=%b fill=%0d required all 0",
               fifo_if.fifo_wr, fifo_if.fifo_rd, fifo_if.fifo_sclr, echo_gate, fill_level);
    end
    repeat (4) @(negedge sysclk);
    wait_drain("collision");
  endtask

  task automatic test_max_depth();
    delay_sel = 3'd7;
    enable    = 1'b1;
    repeat (2) @(negedge sysclk);
    model_start(8192);
    for (int i = 0; i < 8192; i++) send_sample();
    checks++;
    if ({echo_gate, err, fill_level} !== {1'b1, 1'b0, 14'd8192}) begin
      failures++;
      $display("FAIL max_fill gate=%b err=%b fill=%0d required gate=1 err=0 fill=8192",
               echo_gate, err, fill_level);
    end
    fifo_if.fifo_full = 1'b1;
    send_sample();
    fifo_if.fifo_full = 1'b0;
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL full_with_read err=%b required=0", err);
    end
    wait_drain("max_depth");
  endtask

  task automatic test_error_flag();
    fifo_if.fifo_empty = 1'b1;
    send_sample();
    fifo_if.fifo_empty = 1'b0;
    checks++;
    if (err !== 1'b1) begin
      failures++;
      $display("FAIL err_set err=%b required=1", err);
    end
    repeat (5) @(negedge sysclk);
    checks++;
    if (err !== 1'b1) begin
      failures++;
      $display("FAIL err_sticky err=%b required=1", err);
    end
    enable = 1'b0;
    @(negedge sysclk);
    checks++;
    if ({fifo_if.fifo_sclr, err} !== {1'b1, 1'b1}) begin
      failures++;
      $display("FAIL err_flush sclr=%b err=%b required sclr=1 err=1", fifo_if.fifo_sclr, err);
    end
    @(negedge sysclk);
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL err_clear_idle err=%b required=0", err);
    end
    wait_drain("error_flag");
  endtask

  initial begin
    test_reset();
    test_fill_to_run();
    test_delay_change();
    test_collision();
    test_max_depth();
    test_error_flag();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/echo_delay_ctrl.md
# echo_delay_ctrl

Sequencing controller for the echo delay-line FIFO in the voice-alteration datapath. It turns the ADC `data_valid` strobe into FIFO write, read and clear commands, so that the FIFO always holds exactly the selected number of samples. It also gates the echo feedback term until the delay line is primed. It sits between the ADC interface and the delay FIFO, and sits beside the processor block that subtracts the delayed sample.

## Interface
Parameters:
- `DEPTH_LOG2`, default 13: log2 of the FIFO depth (8192 words).
- `STEP_LOG2`, default 10: log2 of the delay granularity in samples (1024).

Ports:
- `sysclk`  in  1: system clock; every flop is clocked on its rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `data_valid`  in  1: ADC sample-valid level; asynchronous to `sysclk`.
- `enable`  in  1: echo on/off request; synchronous level.
- `delay_sel`  in  3: delay select. Target delay D = (delay_sel+1) << STEP_LOG2 samples.
- `fifo_full`  in  1: full flag from the delay FIFO.
- `fifo_empty`  in  1: empty flag from the delay FIFO.
- `fifo_wr`  out  1: one-cycle FIFO write enable.
- `fifo_rd`  out  1: one-cycle FIFO read enable.
- `fifo_sclr`  out  1: synchronous FIFO clear.
- `echo_gate`  out  1: when 1, the datapath applies the delayed sample; when 0, feedback is forced to zero.
- `fill_level`  out  DEPTH_LOG2+1: number of words written to the FIFO and not yet read.
- `err`  out  1: sticky flag for an overflow or underflow protocol error.

## Operation
Sample strobe:
- `data_valid` passes through a two-flop synchronizer followed by a rising-edge detect.
- The result, `strb`, is one cycle wide, once per sample.

FSM states: CLEAR, IDLE, FILL, RUN, FLUSH.
- **CLEAR** (entered on reset): `fifo_sclr`=1. Moves to IDLE on the next clock.
- **IDLE**: no FIFO activity, `echo_gate`=0, `fill_level`=0.
  - If `enable`=1, latch `delay_sel` into `sel_q`, compute D from it, and go to FILL.
- **FILL**: on each `strb`, pulse `fifo_wr` and increment `fill_level`. `echo_gate`=0.
  - When the write that makes `fill_level` equal D is issued, go to RUN.
- **RUN**: on each `strb`, pulse `fifo_wr` and `fifo_rd` in the same cycle. `fill_level` stays at D. `echo_gate`=1.
- **FLUSH**: entered from FILL or RUN when `enable`=0 or `delay_sel`≠`sel_q`.
  - `fifo_sclr`=1 for one cycle, `fill_level` is set to 0, `echo_gate`=0.
  - Next state is IDLE, which re-latches the new `delay_sel` if `enable` is still 1.
- Priority in FILL and RUN: the FLUSH condition beats `strb` in the same cycle, so no write or read is issued in that cycle.

Arithmetic and width rules:
- `fill_level` is unsigned, DEPTH_LOG2+1 bits.
- D is at most 8 << STEP_LOG2. With the defaults that is 8192 = the FIFO depth, which is legal.
- `fill_level` never wraps. An increment above D is impossible by construction of FILL.

Error checks:
- `err` sets if `fifo_wr` is issued while `fifo_full`=1 and `fifo_rd`=0.
- `err` also sets if `fifo_rd` is issued while `fifo_empty`=1.
- `err` clears only on reset or on entry to IDLE.

## Timing
Reset values:
- `fifo_sclr`=1; all other outputs 0; state is CLEAR.
- `fifo_sclr` deasserts on the second rising edge after `rst_n` rises.

Latencies:
- Rising edge of `data_valid` to `strb`: 2–3 `sysclk` cycles (synchronizer).
- `strb` to `fifo_wr`/`fifo_rd`: exactly 1 cycle. All outputs are registered.
- `enable` rise in IDLE to FILL: 1 cycle.
- Mode change in FILL or RUN to `fifo_sclr`: 1 cycle; back to IDLE 1 cycle later.

Transition timing:
- `echo_gate` rises in the cycle after the final FILL write, so the first read happens on the next `strb`.
- `fill_level` updates in the same cycle that `fifo_wr` is asserted.

Reset mid-operation:
- All activity aborts and the FIFO is cleared via CLEAR.
- No partial `fifo_wr` or `fifo_rd` pulse may be emitted during or after reset assertion.

Strobe spacing:
- `strb` pulses must be at least 4 cycles apart; the ADC rate guarantees this.
- Closer strobes are not supported.

## Test plan
- **Reset/clear:**
  - Stimulus: hold `rst_n`=0 for 5 cycles, then release.
  - Required: `fifo_sclr`=1 throughout reset and for 1 cycle after; then state IDLE, all other outputs 0.
- **Fill to RUN:**
  - Stimulus: `enable`=1, `delay_sel`=0, then 1025 `data_valid` pulses.
  - Required: 1024 `fifo_wr` pulses with no `fifo_rd`; `fill_level`=1024 after the last fill write; `echo_gate`=1 after that.
  - On pulse 1025, `fifo_wr` and `fifo_rd` are asserted in the same cycle.
- **Delay change:**
  - Stimulus: in RUN, change `delay_sel` from 0 to 2.
  - Required: one `fifo_sclr` pulse, `fill_level`=0, `echo_gate`=0, then a refill to 3072.
- **Maximum depth:**
  - Stimulus: `delay_sel`=7.
  - Required: FILL issues 8192 writes and ends with `fill_level`=8192.
  - With `fifo_full`=1 in RUN, `err` stays 0 because the read accompanies the write.
- **Collision:**
  - Stimulus: `enable` falls in the same cycle as `strb` during RUN.
  - Required: no `fifo_wr` or `fifo_rd`; `fifo_sclr` pulses; state returns to IDLE.
- **Error flag:**
  - Stimulus: force `fifo_empty`=1 in RUN and send one `strb`.
  - Required: `err`=1, held until `enable`=0 takes the FSM back to IDLE.
